// File: rtl/rr_slot_scheduler.sv
// Round-robin time-slot scheduler for 16 channels; feeds a 4-to-16 decoder.
// Each owner holds the slot for up to SLOT_CYCLES clocks, then ownership rotates.
module rr_slot_scheduler #(
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req_i,
  input  logic        release_i,
  output logic        grant_en_o,
  output logic [3:0]  grant_idx_o,
  output logic        slot_start_o,
  output logic        slot_last_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SLOT_CYCLES - 1);

  state_t           state_q;
  logic [3:0]       ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       grant_idx_q;
  logic             slot_start_q;
  logic             slot_last_q;

  // Returns {found, index}: first set bit of r searching p, p+1, ... mod 16.
  function automatic logic [4:0] arbitrate(input logic [15:0] r, input logic [3:0] p);
    logic [31:0] dbl;
    logic [15:0] rot;
    logic [4:0]  res;
    dbl = {r, r} >> p;
    rot = dbl[15:0];
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rot[i]) res = {1'b1, p + 4'(i)};
    end
    return res;
  endfunction

  logic [3:0] next_ptr_d;
  logic       slot_end_d;
  logic [4:0] arb_idle_d;
  logic [4:0] arb_next_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_ptr_d = grant_idx_q + 4'd1;
    slot_end_d = (cnt_q == '0) || release_i || !req_i[grant_idx_q];
    arb_idle_d = arbitrate(req_i, ptr_q);
    // The current owner sits at the end of this search, so it wins only when alone.
    arb_next_d = arbitrate(req_i, next_ptr_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      grant_idx_q  <= '0;
      slot_start_q <= 1'b0;
      slot_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_idle_d[4]) begin
            state_q      <= GRANT;
            grant_idx_q  <= arb_idle_d[3:0];
            cnt_q        <= RELOAD;
            slot_start_q <= 1'b1;
            slot_last_q  <= (RELOAD == '0);
          end else begin
            slot_start_q <= 1'b0;
            slot_last_q  <= 1'b0;
          end
        end
        GRANT: begin
          if (slot_end_d) begin
            ptr_q <= next_ptr_d;
            if (arb_next_d[4]) begin
              grant_idx_q  <= arb_next_d[3:0];
              cnt_q        <= RELOAD;
              slot_start_q <= 1'b1;
              slot_last_q  <= (RELOAD == '0);
            end else begin
              // grant_idx_q deliberately keeps the last owner while idle.
              state_q      <= IDLE;
              cnt_q        <= '0;
              slot_start_q <= 1'b0;
              slot_last_q  <= 1'b0;
            end
          end else begin
            cnt_q        <= cnt_q - CNT_W'(1);
            slot_start_q <= 1'b0;
            slot_last_q  <= (cnt_q == CNT_W'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_en_o   = (state_q == GRANT);
  assign grant_idx_o  = grant_idx_q;
  assign slot_start_o = slot_start_q;
  assign slot_last_o  = slot_last_q;

endmodule

// File: tb/tb_rr_slot_scheduler.sv
// Scoreboard bench for rr_slot_scheduler: a slot-level reference model predicts
// every cycle's outputs; a monitor pops and compares them after each clock edge.
module tb_rr_slot_scheduler;

  localparam int SLOT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] req;
  logic        rel;
  logic        grant_en;
  logic [3:0]  grant_idx;
  logic        slot_start;
  logic        slot_last;

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
    logic       start;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: slot-level view (owner and cycles used so far).
  bit m_active = 0;
  int m_owner  = 0;
  int m_used   = 0;
  int m_ptr    = 0;

  rr_slot_scheduler #(.SLOT_CYCLES(SLOT), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .release_i    (rel),
    .grant_en_o   (grant_en),
    .grant_idx_o  (grant_idx),
    .slot_start_o (slot_start),
    .slot_last_o  (slot_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t act, input exp_t want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got en=%0b idx=%0d start=%0b last=%0b, want en=%0b idx=%0d start=%0b last=%0b",
               name, act.en, act.idx, act.start, act.last,
               want.en, want.idx, want.start, want.last);
    end
  endtask

  function automatic int find_winner(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  // Advance the model by one clock with the inputs sampled at that edge.
  function automatic exp_t model_step(input logic [15:0] r, input bit rl, input bit rs);
    exp_t e;
    bit   start;
    int   w;
    start = 0;
    if (rs) begin
      m_active = 0; m_owner = 0; m_used = 0; m_ptr = 0;
    end else if (!m_active) begin
      w = find_winner(r, m_ptr);
      if (w >= 0) begin
        m_active = 1; m_owner = w; m_used = 1; start = 1;
      end
    end else if (m_used == SLOT || rl || !r[m_owner]) begin
      m_ptr = (m_owner + 1) % 16;
      w = find_winner(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_used = 1; start = 1;
      end else begin
        m_active = 0;
      end
    end else begin
      m_used++;
    end
    e.en    = m_active;
    e.idx   = 4'(m_owner);
    e.start = start;
    e.last  = m_active && (m_used == SLOT);
    return e;
  endfunction

  // Drive inputs away from the rising edge and queue the response for that edge.
  task automatic step(input logic [15:0] r, input bit rl, input bit rs);
    @(negedge clk);
    req = r; rel = rl; rst = rs;
    exp_q.push_back(model_step(r, rl, rs));
  endtask

  task automatic hold(input logic [15:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic [15:0] r);
    step(r, 1'b0, 1'b1);
    step(r, 1'b0, 1'b1);
  endtask

  // Monitor: the DUT presents registered outputs every cycle.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{en: grant_en, idx: grant_idx, start: slot_start, last: slot_last};
        check("cycle_outputs", a, e);
      end
    end
  end

  initial begin
    int budget;
    logic [15:0] r;
    req = '0; rel = 1'b0; rst = 1'b0;

    // Reset with all requesting, then fairness over several full rotations.
    do_reset(16'hFFFF);
    hold(16'hFFFF, 16 * SLOT * 2 + 3);

    // Single requester holds slot after slot.
    do_reset(16'h0020);
    hold(16'h0020, 13);

    // Rotation with wrap from 15 back to 0.
    do_reset(16'h8003);
    hold(16'h8003, 30);

    // Early end by release, then by owner withdrawal.
    do_reset(16'h0000);
    step(16'h0108, 1'b0, 1'b0);
    step(16'h0108, 1'b0, 1'b0);
    step(16'h0108, 1'b1, 1'b0);
    step(16'h0008, 1'b0, 1'b0);
    hold(16'h0008, 3);

    // All requests drop mid-slot, release while idle, then regrant.
    do_reset(16'h0000);
    hold(16'h0004, 3);
    hold(16'h0000, 1);
    step(16'h0000, 1'b1, 1'b0);
    hold(16'h0000, 1);
    hold(16'h0004, 4);

    // Reset on the 3rd cycle of channel 7's slot, then restart from ptr 0.
    do_reset(16'h0000);
    hold(16'h0081, 1);
    step(16'h0080, 1'b1, 1'b0);
    hold(16'h0080, 2);
    step(16'h0080, 1'b0, 1'b1);
    hold(16'h0081, 6);

    // Randomized traffic with occasional release and reset.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(3))
        0: r = 16'($urandom);
        1: r = 16'($urandom) & 16'($urandom) & 16'($urandom);
        2: r = 16'(1 << $urandom_range(15));
        default: r = req;
      endcase
      step(r, ($urandom_range(7) == 0), ($urandom_range(199) == 0));
    end

    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
